sequenciador_execucao: RTL and testbench
========================================

Name: sequenciador_execucao

Overview:
- Multi-cycle instruction sequencer for the single-cycle-style datapath.
- Gates when the program-counter unit advances, when the instruction register loads, and when the register file and data memory may write.
- Adds start, halt and wait-for-user-input behaviour so the processor can run on the board with a physical confirm button.
- Sits between the decoded control signals and the PC, IR, register-file and memory write enables.

Parameters:
COUNT_WIDTH, 16, width of the retired-instruction counter
WAIT_TIMEOUT, 0, cycles after which WAIT_IO aborts to HALT; 0 disables the timeout

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  level; begins execution from IDLE
is_halt  input  1  decoded instruction is HALT
is_input  input  1  decoded instruction is IN (reads user switches)
mem_read_req  input  1  decoded instruction is a load (needs extra cycle)
reg_write_req  input  1  decoded instruction writes register file
mem_write_req  input  1  decoded instruction writes data memory
io_confirm  input  1  user confirm button, already synchronised and debounced
ir_load  output  1  load instruction register
pc_enable  output  1  clock-enable strobe for PC update (one cycle per instruction)
reg_write_en  output  1  gated register-file write enable
mem_write_en  output  1  gated data-memory write enable
io_wait  output  1  high while waiting for user input
halted  output  1  high in HALT
estado  output  3  current state encoding (debug/display)
instr_count  output  COUNT_WIDTH  instructions retired, saturating

Behaviour:
- States and encodings: IDLE=0, FETCH=1, EXEC=2, MEM=3, WAIT_IO=4, HALT=5. Codes 6–7 go to IDLE on the next edge.
- Reset:
  - estado=IDLE, instr_count=0, edge register=0, timeout counter=0.
  - All outputs are 0 in the reset cycle and the following cycle.
  - Reset overrides everything in any state, including mid-WAIT_IO.
- Output timing:
  - Moore outputs (decoded from estado only): ir_load=1 only in FETCH; io_wait=1 only in WAIT_IO; halted=1 only in HALT.
  - Mealy outputs: pc_enable, reg_write_en and mem_write_en are combinational from estado and inputs. They are asserted only in the cycle listed below and are 0 otherwise.
- IDLE: when start=1, go to FETCH next cycle; otherwise stay.
- FETCH: always go to EXEC. Latency from start to the first ir_load is 1 cycle.
- EXEC, in priority order:
  - is_halt: go to HALT. No pc_enable, no writes, count unchanged.
  - is_input: go to WAIT_IO. No writes yet.
  - mem_read_req: go to MEM. No writes yet.
  - Otherwise (retire): pc_enable=1, reg_write_en=reg_write_req, mem_write_en=mem_write_req, instr_count+1, go to FETCH.
- MEM: pc_enable=1, reg_write_en=1, mem_write_en=0, instr_count+1, go to FETCH.
- WAIT_IO:
  - Rising-edge detection: a rising edge is io_confirm=1 while the previous-cycle sample was 0. The sample register updates every cycle in every state.
  - A button already held high on entry does not retire the instruction; it must be released and pressed again.
  - On a rising edge: pc_enable=1, reg_write_en=1, instr_count+1, go to FETCH.
- WAIT_IO timeout:
  - When WAIT_TIMEOUT>0, a counter runs while in WAIT_IO and clears on exit.
  - On reaching WAIT_TIMEOUT with no edge, go to HALT without retiring.
  - If an edge and the timeout occur in the same cycle, the edge wins.
- HALT: absorbing state; only reset leaves it. start is ignored.
- Instruction rate: normal instructions take 2 cycles, loads 3, IN 2 + user wait.
- instr_count saturates at 2^COUNT_WIDTH-1 and never wraps.
- Input sampling: inputs are sampled only in the states listed above and are ignored elsewhere. The decoded inputs must be stable from FETCH+1 through retirement.

Decomposition:
- Shared package `sequenciador_pkg`: state encodings as localparams (IDLE..HALT), state width 3.
- One natural sub-module, `detector_borda`: 1-bit rising-edge detector with synchronous reset, output = in & ~prev.
- The FSM, saturating counter and timeout counter stay in the top module.

Test Plan:
- Reset, then start=1 with an ALU instruction (reg_write_req=1): ir_load at cycle 1, pc_enable=reg_write_en=1 at cycle 2, instr_count=1, back in FETCH at cycle 3. Run 5 such instructions and expect instr_count=5 after 10 cycles.
- Load (mem_read_req=1): EXEC has no writes, MEM has pc_enable=reg_write_en=1, 3 cycles per instruction. Store (mem_write_req=1): mem_write_en=1 only in EXEC, reg_write_en=0.
- IN with io_confirm held at 1 on entry: stays in WAIT_IO with io_wait=1. Drive 0 for 2 cycles then 1: pc_enable=1 exactly once, on the cycle of the 0→1 transition; next state FETCH.
- is_halt in EXEC: halted=1 from the next cycle, pc_enable never asserted, start toggling ignored. reset=1 for 1 cycle gives estado=0, instr_count=0.
- COUNT_WIDTH=3: retire 10 instructions and expect instr_count=7 (saturated). With WAIT_TIMEOUT=4: enter WAIT_IO with no button and expect HALT 4 cycles later, instr_count unchanged.
- Assert reset mid-WAIT_IO and mid-MEM: the next cycle has estado=IDLE with all write enables 0, and no spurious pc_enable.

Source files
------------

// File: rtl/sequenciador_pkg.sv
// Shared definitions for the instruction sequencer: state width and encodings.
package sequenciador_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] estado_t;

  localparam estado_t IDLE    = 3'd0;
  localparam estado_t FETCH   = 3'd1;
  localparam estado_t EXEC    = 3'd2;
  localparam estado_t MEM     = 3'd3;
  localparam estado_t WAIT_IO = 3'd4;
  localparam estado_t HALT    = 3'd5;

endpackage

// File: rtl/sequenciador_execucao_detector_borda.sv
// One-bit rising-edge detector: flags the cycle where the input goes 0 -> 1.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic borda
);

  logic anterior_r;

  // Previous-cycle sample, updated every cycle regardless of FSM state
  always_ff @(posedge clock) begin
    if (reset) begin
      anterior_r <= 1'b0;
    end else begin
      anterior_r <= sinal;
    end
  end

  assign borda = sinal & ~anterior_r;

endmodule

// File: rtl/sequenciador_execucao.sv
// Multi-cycle sequencer gating PC, IR, register-file and data-memory enables,
// with start/halt control and a wait state for the board's confirm button.
module sequenciador_execucao
  import sequenciador_pkg::*;
#(
  parameter int COUNT_WIDTH  = 16,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   is_halt,
  input  logic                   is_input,
  input  logic                   mem_read_req,
  input  logic                   reg_write_req,
  input  logic                   mem_write_req,
  input  logic                   io_confirm,
  output logic                   ir_load,
  output logic                   pc_enable,
  output logic                   reg_write_en,
  output logic                   mem_write_en,
  output logic                   io_wait,
  output logic                   halted,
  output logic [STATE_W-1:0]     estado,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam int TIMER_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = {COUNT_WIDTH{1'b1}};
  localparam logic [TIMER_W-1:0]     TIMER_LAST =
    TIMER_W'((WAIT_TIMEOUT > 0) ? (WAIT_TIMEOUT - 1) : 0);

  estado_t                estado_r;
  estado_t                proximo_s;
  logic [COUNT_WIDTH-1:0] count_r;
  logic [TIMER_W-1:0]     timer_r;
  logic                   borda_s;
  logic                   timeout_s;
  logic                   retire_s;
  logic                   pc_en_s;
  logic                   reg_we_s;
  logic                   mem_we_s;

  detector_borda u_detector_borda (
    .clock (clock),
    .reset (reset),
    .sinal (io_confirm),
    .borda (borda_s)
  );

  assign timeout_s = (WAIT_TIMEOUT > 0) && (timer_r == TIMER_LAST);

  // Next-state and retirement decode; the write strobes are Mealy on purpose
  always_comb begin
    proximo_s = estado_r;
    retire_s  = 1'b0;
    pc_en_s   = 1'b0;
    reg_we_s  = 1'b0;
    mem_we_s  = 1'b0;
    case (estado_r)
      IDLE: begin
        if (start) begin
          proximo_s = FETCH;
        end else begin
          proximo_s = IDLE;
        end
      end
      FETCH: begin
        proximo_s = EXEC;
      end
      EXEC: begin
        if (is_halt) begin
          proximo_s = HALT;
        end else if (is_input) begin
          proximo_s = WAIT_IO;
        end else if (mem_read_req) begin
          proximo_s = MEM;
        end else begin
          retire_s  = 1'b1;
          pc_en_s   = 1'b1;
          reg_we_s  = reg_write_req;
          mem_we_s  = mem_write_req;
          proximo_s = FETCH;
        end
      end
      MEM: begin
        retire_s  = 1'b1;
        pc_en_s   = 1'b1;
        reg_we_s  = 1'b1;
        proximo_s = FETCH;
      end
      WAIT_IO: begin
        // A press in the same cycle as the timeout still retires the IN
        if (borda_s) begin
          retire_s  = 1'b1;
          pc_en_s   = 1'b1;
          reg_we_s  = 1'b1;
          proximo_s = FETCH;
        end else if (timeout_s) begin
          proximo_s = HALT;
        end else begin
          proximo_s = WAIT_IO;
        end
      end
      HALT: begin
        proximo_s = HALT;
      end
      default: begin
        proximo_s = IDLE;
      end
    endcase
  end

  // State, saturating retired-instruction counter and WAIT_IO timer
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r <= IDLE;
      count_r  <= {COUNT_WIDTH{1'b0}};
      timer_r  <= {TIMER_W{1'b0}};
    end else begin
      estado_r <= proximo_s;
      if (retire_s && (count_r != COUNT_MAX)) begin
        count_r <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if ((WAIT_TIMEOUT > 0) && (estado_r == WAIT_IO) && (proximo_s == WAIT_IO)) begin
        timer_r <= timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
      end else begin
        timer_r <= {TIMER_W{1'b0}};
      end
    end
  end

  // Reset masks every output so nothing leaks during the reset cycle
  assign ir_load      = !reset && (estado_r == FETCH);
  assign io_wait      = !reset && (estado_r == WAIT_IO);
  assign halted       = !reset && (estado_r == HALT);
  assign pc_enable    = !reset && pc_en_s;
  assign reg_write_en = !reset && reg_we_s;
  assign mem_write_en = !reset && mem_we_s;
  assign estado       = reset ? IDLE : estado_r;
  assign instr_count  = reset ? {COUNT_WIDTH{1'b0}} : count_r;

endmodule

// File: tb/tb_sequenciador_execucao.sv
// Scoreboard bench: two sequencer instances (default, and 3-bit count with
// WAIT_TIMEOUT=4) share one stimulus stream; expected per-cycle outputs are queued.
module tb_sequenciador_execucao;
  import sequenciador_pkg::*;

  logic clock = 1'b0;
  logic reset, start, is_halt, is_input, mem_read_req, reg_write_req, mem_write_req, io_confirm;

  logic        a_ir, a_pc, a_rw, a_mw, a_iow, a_hlt;
  logic [2:0]  a_est;
  logic [15:0] a_cnt;
  logic        b_ir, b_pc, b_rw, b_mw, b_iow, b_hlt;
  logic [2:0]  b_est;
  logic [2:0]  b_cnt;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_IR   = 6'b100000;
  localparam logic [5:0] S_PCRW = 6'b011000;
  localparam logic [5:0] S_PCMW = 6'b010100;
  localparam logic [5:0] S_WAIT = 6'b000010;
  localparam logic [5:0] S_WPC  = 6'b011010;
  localparam logic [5:0] S_HALT = 6'b000001;

  typedef struct {
    logic [2:0]  est;
    logic [5:0]  str;
    logic [15:0] cnt;
    logic [2:0]  b_est;
    logic [2:0]  b_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  sequenciador_execucao dut_a (
    .clock(clock), .reset(reset), .start(start), .is_halt(is_halt), .is_input(is_input),
    .mem_read_req(mem_read_req), .reg_write_req(reg_write_req), .mem_write_req(mem_write_req),
    .io_confirm(io_confirm), .ir_load(a_ir), .pc_enable(a_pc), .reg_write_en(a_rw),
    .mem_write_en(a_mw), .io_wait(a_iow), .halted(a_hlt), .estado(a_est), .instr_count(a_cnt)
  );

  sequenciador_execucao #(.COUNT_WIDTH(3), .WAIT_TIMEOUT(4)) dut_b (
    .clock(clock), .reset(reset), .start(start), .is_halt(is_halt), .is_input(is_input),
    .mem_read_req(mem_read_req), .reg_write_req(reg_write_req), .mem_write_req(mem_write_req),
    .io_confirm(io_confirm), .ir_load(b_ir), .pc_enable(b_pc), .reg_write_en(b_rw),
    .mem_write_en(b_mw), .io_wait(b_iow), .halted(b_hlt), .estado(b_est), .instr_count(b_cnt)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Push one cycle of expectations, then let that cycle elapse
  task automatic c2(input logic [2:0] est, input logic [5:0] str, input int cnt,
                    input logic [2:0] best, input int bcnt);
    exp_t e;
    e.est = est; e.str = str; e.cnt = 16'(cnt); e.b_est = best; e.b_cnt = 3'(bcnt);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("a_estado", 32'(a_est), 32'(e.est));
      check_val("a_strobes", 32'({a_ir, a_pc, a_rw, a_mw, a_iow, a_hlt}), 32'(e.str));
      check_val("a_count", 32'(a_cnt), 32'(e.cnt));
      check_val("b_estado", 32'(b_est), 32'(e.b_est));
      check_val("b_count", 32'(b_cnt), 32'(e.b_cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; is_halt = 1'b0; is_input = 1'b0; mem_read_req = 1'b0;
    reg_write_req = 1'b0; mem_write_req = 1'b0; io_confirm = 1'b0;
    @(posedge clock);
    #1;
    c2(IDLE, S_NONE, 0, IDLE, 0);
    reset = 1'b0;
    c2(IDLE, S_NONE, 0, IDLE, 0);

    // Five ALU instructions, 2 cycles each
    start = 1'b1; reg_write_req = 1'b1;
    c2(IDLE, S_NONE, 0, IDLE, 0);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c2(FETCH, S_IR, i, FETCH, i);
      c2(EXEC, S_PCRW, i, EXEC, i);
    end

    // Two loads, 3 cycles each
    reg_write_req = 1'b0; mem_read_req = 1'b1;
    for (int i = 5; i < 7; i++) begin
      c2(FETCH, S_IR, i, FETCH, i);
      c2(EXEC, S_NONE, i, EXEC, i);
      c2(MEM, S_PCRW, i, MEM, i);
    end

    // Store: memory write in EXEC only, no register write
    mem_read_req = 1'b0; mem_write_req = 1'b1;
    c2(FETCH, S_IR, 7, FETCH, 7);
    c2(EXEC, S_PCMW, 7, EXEC, 7);

    // Two more ALU ops: the 3-bit counter stays saturated at 7
    mem_write_req = 1'b0; reg_write_req = 1'b1;
    for (int i = 8; i < 10; i++) begin
      c2(FETCH, S_IR, i, FETCH, 7);
      c2(EXEC, S_PCRW, i, EXEC, 7);
    end

    // IN with button held on entry; release 2 cycles then press (edge beats timeout in B)
    reg_write_req = 1'b0; is_input = 1'b1; io_confirm = 1'b1;
    c2(FETCH, S_IR, 10, FETCH, 7);
    c2(EXEC, S_NONE, 10, EXEC, 7);
    c2(WAIT_IO, S_WAIT, 10, WAIT_IO, 7);
    io_confirm = 1'b0;
    c2(WAIT_IO, S_WAIT, 10, WAIT_IO, 7);
    c2(WAIT_IO, S_WAIT, 10, WAIT_IO, 7);
    io_confirm = 1'b1;
    c2(WAIT_IO, S_WPC, 10, WAIT_IO, 7);

    // IN with no button: B times out to HALT after 4 cycles, A keeps waiting
    io_confirm = 1'b0;
    c2(FETCH, S_IR, 11, FETCH, 7);
    c2(EXEC, S_NONE, 11, EXEC, 7);
    for (int i = 0; i < 4; i++) c2(WAIT_IO, S_WAIT, 11, WAIT_IO, 7);
    c2(WAIT_IO, S_WAIT, 11, HALT, 7);
    io_confirm = 1'b1;
    c2(WAIT_IO, S_WPC, 11, HALT, 7);

    // HALT: no pc_enable, no writes, start ignored
    io_confirm = 1'b0; is_input = 1'b0; is_halt = 1'b1; reg_write_req = 1'b1; mem_write_req = 1'b1;
    c2(FETCH, S_IR, 12, HALT, 7);
    c2(EXEC, S_NONE, 12, HALT, 7);
    for (int k = 0; k < 4; k++) begin
      start = (k % 2 == 0);
      c2(HALT, S_HALT, 12, HALT, 7);
    end

    start = 1'b0; is_halt = 1'b0; reg_write_req = 1'b0; mem_write_req = 1'b0; reset = 1'b1;
    c2(IDLE, S_NONE, 0, IDLE, 0);
    reset = 1'b0;
    c2(IDLE, S_NONE, 0, IDLE, 0);

    // Reset while in WAIT_IO, with a button press arriving in the reset cycle
    start = 1'b1; is_input = 1'b1;
    c2(IDLE, S_NONE, 0, IDLE, 0);
    start = 1'b0;
    c2(FETCH, S_IR, 0, FETCH, 0);
    c2(EXEC, S_NONE, 0, EXEC, 0);
    c2(WAIT_IO, S_WAIT, 0, WAIT_IO, 0);
    reset = 1'b1; io_confirm = 1'b1;
    c2(IDLE, S_NONE, 0, IDLE, 0);
    reset = 1'b0; io_confirm = 1'b0; is_input = 1'b0;
    c2(IDLE, S_NONE, 0, IDLE, 0);

    // Reset while in MEM
    start = 1'b1; mem_read_req = 1'b1;
    c2(IDLE, S_NONE, 0, IDLE, 0);
    start = 1'b0;
    c2(FETCH, S_IR, 0, FETCH, 0);
    c2(EXEC, S_NONE, 0, EXEC, 0);
    reset = 1'b1;
    c2(IDLE, S_NONE, 0, IDLE, 0);
    reset = 1'b0; mem_read_req = 1'b0;
    c2(IDLE, S_NONE, 0, IDLE, 0);

    // Counting resumes cleanly after reset
    start = 1'b1; reg_write_req = 1'b1;
    c2(IDLE, S_NONE, 0, IDLE, 0);
    start = 1'b0;
    c2(FETCH, S_IR, 0, FETCH, 0);
    c2(EXEC, S_PCRW, 0, EXEC, 0);
    c2(FETCH, S_IR, 1, FETCH, 1);

    check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
